vote_controller: RTL and testbench
==================================

# vote_controller

Sequencing and arbitration controller for the voting system. It shares five candidate tally counters (A–E) between `NUM_BOOTHS` voting booths through a round-robin req/ack handshake. It runs the election phases (idle, open, scan, done) and, after polls close, serially scans the tallies to produce the maximum count, one-hot winner flags and a tie flag. Its tally outputs are the operands the max/winner comparison datapath consumes.

## Interface
- `NUM_BOOTHS`, default 4: number of requesting booths, range 2–8.
- `CNT_W`, default 32: width of each tally, of `max_votes` and of `invalid_cnt`.
- `clk` in 1: single clock. All state updates on the rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `start` in 1: level sampled each edge. Begins a new election from IDLE or DONE.
- `close` in 1: level sampled each edge. Ends voting while OPEN.
- `booth_req` in `NUM_BOOTHS`: per-booth vote request. Held with its vote until acked.
- `booth_vote` in `3*NUM_BOOTHS`: candidate index per booth (bits 3i+2:3i). 0=A … 4=E, 5–7 invalid.
- `booth_ack` out `NUM_BOOTHS`: one-cycle grant/accept pulse, at most one bit high.
- `tally_a`..`tally_e` out `CNT_W` each: candidate vote counts.
- `invalid_cnt` out `CNT_W`: number of accepted votes with index > 4.
- `max_votes` out `CNT_W`: largest tally, valid when `result_valid`=1.
- `win` out 5: one-hot or multi-hot winner flags, bit0=A … bit4=E. Valid when `result_valid`=1.
- `tie` out 1: more than one `win` bit set.
- `result_valid` out 1: high only in DONE.
- `state` out 2: IDLE=0, OPEN=1, SCAN=2, DONE=3.

## Operation
- **Reset** (`rst`=0, asynchronous, any state):
  - `state`=IDLE.
  - All tallies, `invalid_cnt`, `max_votes`, `win`, `tie`, `result_valid`, `booth_ack` = 0.
  - Round-robin pointer and scan index = 0.
- **IDLE:** `start`=1 moves to OPEN. `close` is ignored.
- **OPEN arbitration:**
  - Each edge with `close`=0, select the first requesting booth at or after the pointer, wrapping modulo `NUM_BOOTHS`.
  - Any booth whose `booth_ack` is currently high is masked from selection.
  - For the selected booth g:
    - `booth_ack[g]`=1 in the next cycle.
    - The pointer moves to (g+1) mod `NUM_BOOTHS`.
    - The tally for the candidate in `booth_vote[g]` increments, or `invalid_cnt` increments for index 5–7.
  - With no unmasked request: no ack, and the pointer holds.
  - Booth protocol: keep `req` and `vote` stable until `ack` is seen, then deassert. A still-high `req` in the ack cycle is never double-counted, because of the mask.
- **Saturation:** a tally or `invalid_cnt` at all-ones stays at all-ones. The vote is still acked.
- **close in OPEN:** no grant on that edge. Move to SCAN, with scan index=0 and the running max=0. An ack from the previous edge still completes normally. `start` is ignored in OPEN.
- **SCAN:**
  - On each edge: running max = max(running max, tally[idx]); idx++.
  - On the edge with idx=4, move to DONE and register:
    - `max_votes` = final max.
    - `win[i]` = (tally_i == final max).
    - `tie` = popcount(`win`) > 1.
  - `start`, `close` and `booth_req` are ignored in SCAN. No acks are issued.
- **DONE:** results and tallies are held. `start`=1 moves to OPEN.
- **Entering OPEN** (from IDLE or DONE): on that edge, clear tallies, `invalid_cnt`, `max_votes`, `win`, `tie`, `result_valid`, and the scan index.
- **All-zero election:** `max_votes`=0, `win`=5'b11111, `tie`=1.

## Timing
- Vote latency: `req` sampled at edge E gives `ack` and the updated tally visible after E, one cycle.
- Throughput: up to 1 vote per cycle in aggregate; 1 vote per 2 cycles per booth.
- Result latency: `close` sampled at edge E0 gives SCAN during cycles E0..E5, and `state`=DONE with `result_valid`=1 after E5, i.e. 5 edges.
- Simultaneous events:
  - `close` with requests pending: `close` wins and the requests get no ack.
  - `start` with `close` in IDLE/DONE: `start` wins and `close` is ignored.
- Reset mid-SCAN or mid-OPEN: all outputs return to reset values immediately, without waiting for a clock edge.

## Test plan
- **Single booth vote:** reset, `start`, booth0 votes C once, then `close` → `tally_c`=1, others 0. After 5 edges: `max_votes`=1, `win`=00100, `tie`=0, `state`=3.
- **Round-robin fairness:** 4 booths request continuously (re-requesting 1 cycle after each ack) for 8 cycles → ack order 0,1,2,3,0,1,2,3 and never the same booth on consecutive cycles.
- **Tie:** votes A=3, D=3, B=1 → `max_votes`=3, `win`=01001, `tie`=1.
- **Invalid vote and close collision:**
  - Booth1 votes index 6 → `invalid_cnt`=1, tallies unchanged, ack still issued.
  - `close` asserted with booth2 requesting → no ack to booth2, `state`=2.
- **Saturation:** `CNT_W`=4, 17 votes for E → `tally_e`=15, 17 acks.
- **Async reset mid-SCAN:** `rst` low two cycles after `close` → `state`=0 and all outputs 0 before the next edge. A new `start` then gives clean zero tallies.

Source files
------------

// File: rtl/vote_controller.sv
// rtl/vote_controller.sv - round-robin vote arbiter, tally keeper and winner scanner
//
// Purpose:
//   Shares five candidate tallies (A..E) between NUM_BOOTHS booths using a
//   round-robin req/ack handshake. It steps through the election phases
//   IDLE -> OPEN -> SCAN -> DONE. Once the polls close, it scans the tallies
//   one at a time to produce the maximum count, the winner flags and a tie flag.
//
// Ports:
//   clk           - single clock, all state changes on the rising edge
//   rst           - asynchronous active-low reset
//   start         - begin a new election (from IDLE or DONE)
//   close         - end voting (while OPEN)
//   booth_req     - per-booth request, held with its vote until acked
//   booth_vote    - 3-bit candidate index per booth, 0=A..4=E, 5..7 invalid
//   booth_ack     - one-cycle accept pulse, at most one bit set
//   tally_a..e    - candidate vote counts (saturating)
//   invalid_cnt   - accepted votes carrying an index above 4 (saturating)
//   max_votes     - largest tally, valid with result_valid
//   win           - winner flags, bit0=A..bit4=E, valid with result_valid
//   tie           - more than one win bit set
//   result_valid  - high only in DONE
//   state         - IDLE=0, OPEN=1, SCAN=2, DONE=3

module vote_controller #(
    parameter int NUM_BOOTHS = 4,
    parameter int CNT_W      = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    close,
    input  logic [NUM_BOOTHS-1:0]   booth_req,
    input  logic [3*NUM_BOOTHS-1:0] booth_vote,
    output logic [NUM_BOOTHS-1:0]   booth_ack,
    output logic [CNT_W-1:0]        tally_a,
    output logic [CNT_W-1:0]        tally_b,
    output logic [CNT_W-1:0]        tally_c,
    output logic [CNT_W-1:0]        tally_d,
    output logic [CNT_W-1:0]        tally_e,
    output logic [CNT_W-1:0]        invalid_cnt,
    output logic [CNT_W-1:0]        max_votes,
    output logic [4:0]              win,
    output logic                    tie,
    output logic                    result_valid,
    output logic [1:0]              state
);

    localparam int PTR_W = (NUM_BOOTHS > 1) ? $clog2(NUM_BOOTHS) : 1;
    localparam logic [CNT_W-1:0] ALL_ONES = '1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OPEN = 2'd1,
        ST_SCAN = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t           cur_state;
    logic [PTR_W-1:0] rr_ptr;
    logic [2:0]       scan_idx;
    logic [CNT_W-1:0] run_max;
    logic [CNT_W-1:0] tally [5];

    // Arbitration: first unmasked request at or after the pointer. A booth
    // whose ack is high this cycle is still allowed to hold req, so it is
    // masked out to keep it from being counted twice.
    logic [NUM_BOOTHS-1:0] avail;
    logic                  gnt_valid;
    logic [PTR_W-1:0]      gnt_idx;
    logic [PTR_W-1:0]      gnt_next_ptr;
    logic [2:0]            gnt_vote;
    int                    cand;

    always_comb begin
        avail     = booth_req & ~booth_ack;
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        cand      = 0;
        for (int k = 0; k < NUM_BOOTHS; k++) begin
            cand = int'(rr_ptr) + k;
            if (cand >= NUM_BOOTHS) begin
                cand = cand - NUM_BOOTHS;
            end
            if (!gnt_valid && avail[cand]) begin
                gnt_valid = 1'b1;
                gnt_idx   = PTR_W'(cand);
            end
        end
        gnt_vote     = booth_vote[3*gnt_idx +: 3];
        gnt_next_ptr = (gnt_idx == PTR_W'(NUM_BOOTHS - 1)) ? '0 : gnt_idx + PTR_W'(1);
    end

    // Scan step: fold the tally at scan_idx into the running max. On the last
    // step this is the final maximum, so the winner flags come from it directly.
    logic [CNT_W-1:0] scan_val;
    logic [CNT_W-1:0] final_max;
    logic [4:0]       win_next;
    logic             tie_next;

    always_comb begin
        scan_val  = (scan_idx <= 3'd4) ? tally[scan_idx] : '0;
        final_max = (scan_val > run_max) ? scan_val : run_max;
        for (int i = 0; i < 5; i++) begin
            win_next[i] = (tally[i] == final_max);
        end
        // More than one bit set <=> clearing the lowest set bit leaves something.
        tie_next = ((win_next & (win_next - 5'd1)) != 5'd0);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cur_state    <= ST_IDLE;
            rr_ptr       <= '0;
            scan_idx     <= '0;
            run_max      <= '0;
            for (int i = 0; i < 5; i++) begin
                tally[i] <= '0;
            end
            invalid_cnt  <= '0;
            max_votes    <= '0;
            win          <= '0;
            tie          <= 1'b0;
            result_valid <= 1'b0;
            booth_ack    <= '0;
        end else begin
            booth_ack <= '0;
            case (cur_state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        cur_state    <= ST_OPEN;
                        for (int i = 0; i < 5; i++) begin
                            tally[i] <= '0;
                        end
                        invalid_cnt  <= '0;
                        max_votes    <= '0;
                        win          <= '0;
                        tie          <= 1'b0;
                        result_valid <= 1'b0;
                        scan_idx     <= '0;
                    end
                end
                ST_OPEN: begin
                    // close takes priority over any pending request.
                    if (close) begin
                        cur_state <= ST_SCAN;
                        scan_idx  <= '0;
                        run_max   <= '0;
                    end else if (gnt_valid) begin
                        booth_ack <= NUM_BOOTHS'(1) << gnt_idx;
                        rr_ptr    <= gnt_next_ptr;
                        if (gnt_vote <= 3'd4) begin
                            if (tally[gnt_vote] != ALL_ONES) begin
                                tally[gnt_vote] <= tally[gnt_vote] + CNT_W'(1);
                            end
                        end else if (invalid_cnt != ALL_ONES) begin
                            invalid_cnt <= invalid_cnt + CNT_W'(1);
                        end
                    end
                end
                ST_SCAN: begin
                    run_max <= final_max;
                    if (scan_idx == 3'd4) begin
                        cur_state    <= ST_DONE;
                        max_votes    <= final_max;
                        win          <= win_next;
                        tie          <= tie_next;
                        result_valid <= 1'b1;
                    end else begin
                        scan_idx <= scan_idx + 3'd1;
                    end
                end
                default: cur_state <= ST_IDLE;
            endcase
        end
    end

    assign tally_a = tally[0];
    assign tally_b = tally[1];
    assign tally_c = tally[2];
    assign tally_d = tally[3];
    assign tally_e = tally[4];
    assign state   = cur_state;

endmodule

// File: tb/tb_vote_controller.sv
// tb/tb_vote_controller.sv - self-checking bench for vote_controller

module tb_vote_controller;

    localparam int N  = 4;
    localparam int W  = 32;
    localparam int SN = 2;
    localparam int SW = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic           start, close;
    logic [N-1:0]   req;
    logic [3*N-1:0] vote;
    logic [N-1:0]   ack;
    logic [W-1:0]   ta, tb, tc, td, te, inv, mx;
    logic [4:0]     win;
    logic           tie, rv;
    logic [1:0]     st;

    logic            s_start, s_close;
    logic [SN-1:0]   s_req;
    logic [3*SN-1:0] s_vote;
    logic [SN-1:0]   s_ack;
    logic [SW-1:0]   s_ta, s_tb, s_tc, s_td, s_te, s_inv, s_mx;
    logic [4:0]      s_win;
    logic            s_tie, s_rv;
    logic [1:0]      s_st;

    int tests = 0;
    int fails = 0;

    vote_controller #(.NUM_BOOTHS(N), .CNT_W(W)) dut (
        .clk(clk), .rst(rst), .start(start), .close(close),
        .booth_req(req), .booth_vote(vote), .booth_ack(ack),
        .tally_a(ta), .tally_b(tb), .tally_c(tc), .tally_d(td), .tally_e(te),
        .invalid_cnt(inv), .max_votes(mx), .win(win), .tie(tie),
        .result_valid(rv), .state(st)
    );

    vote_controller #(.NUM_BOOTHS(SN), .CNT_W(SW)) dut_sat (
        .clk(clk), .rst(rst), .start(s_start), .close(s_close),
        .booth_req(s_req), .booth_vote(s_vote), .booth_ack(s_ack),
        .tally_a(s_ta), .tally_b(s_tb), .tally_c(s_tc), .tally_d(s_td), .tally_e(s_te),
        .invalid_cnt(s_inv), .max_votes(s_mx), .win(s_win), .tie(s_tie),
        .result_valid(s_rv), .state(s_st)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W-1:0] get_tally(input int i);
        case (i)
            0: return ta;
            1: return tb;
            2: return tc;
            3: return td;
            4: return te;
            5: return inv;
            default: return '0;
        endcase
    endfunction

    task automatic do_reset();
        rst = 1'b0;
        start = 1'b0; close = 1'b0; req = '0; vote = '0;
        s_start = 1'b0; s_close = 1'b0; s_req = '0; s_vote = '0;
        repeat (2) tick();
        rst = 1'b1;
        tick();
    endtask

    task automatic open_poll();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic close_and_scan();
        close = 1'b1;
        req = '0;
        tick();
        close = 1'b0;
        repeat (5) tick();
    endtask

    // One booth casts one vote following the booth protocol; ok reports whether an ack came.
    task automatic cast_vote(input int b, input int v, output bit ok);
        ok = 1'b0;
        req[b] = 1'b1;
        vote[3*b +: 3] = 3'(v);
        for (int i = 0; i < 8 && !ok; i++) begin
            tick();
            if (ack[b]) ok = 1'b1;
        end
        req[b] = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        start = 1'b0; close = 1'b0; req = '0; vote = '0;
        s_start = 1'b0; s_close = 1'b0; s_req = '0; s_vote = '0;
        #3;
        tests++;
        if (st !== 2'd0) begin fails++; $display("FAIL reset_state: got %0d expected 0", st); end
        tests++;
        if ({ta, tb, tc, td, te, inv, mx} !== '0) begin
            fails++; $display("FAIL reset_tallies: got nonzero, expected all 0");
        end
        tests++;
        if ({win, tie, rv, ack} !== '0) begin
            fails++; $display("FAIL reset_flags: got win=%b tie=%b rv=%b ack=%b expected 0", win, tie, rv, ack);
        end
        do_reset();
    endtask

    task automatic test_single_vote();
        bit ok;
        open_poll();
        tests++;
        if (st !== 2'd1) begin fails++; $display("FAIL single_open: state=%0d expected 1", st); end
        cast_vote(0, 2, ok);
        tests++;
        if (!ok) begin fails++; $display("FAIL single_ack: no ack, expected ack"); end
        tests++;
        if (tc !== 1 || {ta, tb, td, te, inv} !== '0) begin
            fails++; $display("FAIL single_tally: got c=%0d a=%0d b=%0d d=%0d e=%0d expected c=1 rest 0", tc, ta, tb, td, te);
        end
        close = 1'b1;
        tick();
        close = 1'b0;
        repeat (4) tick();
        tests++;
        if (st !== 2'd2 || rv !== 1'b0) begin
            fails++; $display("FAIL single_scan_len: state=%0d rv=%b expected 2 0 after 4 scan edges", st, rv);
        end
        tick();
        tests++;
        if (st !== 2'd3 || rv !== 1'b1 || mx !== 1 || win !== 5'b00100 || tie !== 1'b0) begin
            fails++; $display("FAIL single_result: state=%0d rv=%b max=%0d win=%b tie=%b expected 3 1 1 00100 0", st, rv, mx, win, tie);
        end
    endtask

    task automatic test_round_robin();
        logic [N-1:0] rearm;
        logic [N-1:0] exp_ack;
        int cnt[6];
        int v;
        do_reset();
        open_poll();
        rearm = '0;
        for (int i = 0; i < 6; i++) cnt[i] = 0;
        for (int b = 0; b < N; b++) begin
            req[b] = 1'b1;
            vote[3*b +: 3] = 3'($urandom_range(4));
        end
        for (int i = 0; i < 8; i++) begin
            tick();
            exp_ack = N'(1) << (i % N);
            tests++;
            if (ack !== exp_ack) begin
                fails++; $display("FAIL rr_order[%0d]: ack=%b expected %b", i, ack, exp_ack);
            end
            for (int b = 0; b < N; b++) begin
                if (rearm[b]) begin
                    req[b] = 1'b1;
                    vote[3*b +: 3] = 3'($urandom_range(4));
                    rearm[b] = 1'b0;
                end else if (ack[b]) begin
                    v = int'(vote[3*b +: 3]);
                    cnt[v]++;
                    req[b] = 1'b0;
                    rearm[b] = 1'b1;
                end
            end
        end
        req = '0;
        tick();
        for (int i = 0; i < 5; i++) begin
            tests++;
            if (get_tally(i) !== W'(cnt[i])) begin
                fails++; $display("FAIL rr_tally[%0d]: got %0d expected %0d", i, get_tally(i), cnt[i]);
            end
        end
    endtask

    task automatic test_tie();
        bit ok, all_ok;
        all_ok = 1'b1;
        open_poll();
        for (int i = 0; i < 3; i++) begin
            cast_vote(0, 0, ok); all_ok &= ok;
            cast_vote(1, 3, ok); all_ok &= ok;
        end
        cast_vote(2, 1, ok); all_ok &= ok;
        tests++;
        if (!all_ok) begin fails++; $display("FAIL tie_acks: some vote not acked, expected all acked"); end
        close_and_scan();
        tests++;
        if (mx !== 3 || win !== 5'b01001 || tie !== 1'b1 || st !== 2'd3) begin
            fails++; $display("FAIL tie_result: max=%0d win=%b tie=%b state=%0d expected 3 01001 1 3", mx, win, tie, st);
        end
    endtask

    task automatic test_invalid_close();
        bit ok;
        open_poll();
        tests++;
        if ({ta, tb, tc, td, te, inv, mx, win, tie, rv} !== '0) begin
            fails++; $display("FAIL restart_clear: got d=%0d max=%0d rv=%b expected all 0", td, mx, rv);
        end
        cast_vote(1, 6, ok);
        tests++;
        if (!ok || inv !== 1 || {ta, tb, tc, td, te} !== '0) begin
            fails++; $display("FAIL invalid_vote: ack=%b inv=%0d expected 1 1 and tallies 0", ok, inv);
        end
        req[2] = 1'b1;
        vote[8:6] = 3'd0;
        close = 1'b1;
        tick();
        tests++;
        if (ack !== '0 || st !== 2'd2 || ta !== 0) begin
            fails++; $display("FAIL close_wins: ack=%b state=%0d a=%0d expected 0000 2 0", ack, st, ta);
        end
        req = '0;
        close = 1'b0;
        repeat (5) tick();
        tests++;
        if (mx !== 0 || win !== 5'b11111 || tie !== 1'b1 || rv !== 1'b1) begin
            fails++; $display("FAIL all_zero: max=%0d win=%b tie=%b rv=%b expected 0 11111 1 1", mx, win, tie, rv);
        end
    endtask

    task automatic test_saturation();
        int acks;
        int b;
        bit got;
        acks = 0;
        s_start = 1'b1;
        tick();
        s_start = 1'b0;
        for (int i = 0; i < 17; i++) begin
            b = i % SN;
            s_req[b] = 1'b1;
            s_vote[3*b +: 3] = 3'd4;
            got = 1'b0;
            for (int t = 0; t < 8 && !got; t++) begin
                tick();
                if (s_ack[b]) begin got = 1'b1; acks++; end
            end
            s_req[b] = 1'b0;
            tick();
        end
        tests++;
        if (s_te !== 4'd15 || acks != 17 || s_inv !== 4'd0) begin
            fails++; $display("FAIL saturation: tally_e=%0d acks=%0d inv=%0d expected 15 17 0", s_te, acks, s_inv);
        end
        s_close = 1'b1;
        tick();
        s_close = 1'b0;
        repeat (5) tick();
        tests++;
        if (s_mx !== 4'd15 || s_win !== 5'b10000 || s_tie !== 1'b0 || s_st !== 2'd3) begin
            fails++; $display("FAIL sat_result: max=%0d win=%b tie=%b state=%0d expected 15 10000 0 3", s_mx, s_win, s_tie, s_st);
        end
    endtask

    task automatic test_random();
        int ptr, g, idx, v, mxv, nw;
        logic [N-1:0] eack, nack, avail;
        logic [4:0] ew;
        int cnt[6];
        bit late[N];
        do_reset();
        open_poll();
        ptr = 0;
        eack = '0;
        for (int i = 0; i < 6; i++) cnt[i] = 0;
        for (int b = 0; b < N; b++) late[b] = 1'b0;
        for (int cyc = 0; cyc < 300; cyc++) begin
            avail = req & ~eack;
            nack = '0;
            g = -1;
            for (int k = 0; k < N; k++) begin
                idx = (ptr + k) % N;
                if (g < 0 && avail[idx]) g = idx;
            end
            if (g >= 0) begin
                nack[g] = 1'b1;
                ptr = (g + 1) % N;
                v = int'(vote[3*g +: 3]);
                cnt[(v > 4) ? 5 : v]++;
            end
            tick();
            tests++;
            if (ack !== nack) begin
                fails++; $display("FAIL rand_ack[%0d]: ack=%b expected %b", cyc, ack, nack);
            end
            eack = nack;
            for (int b = 0; b < N; b++) begin
                if (late[b]) begin
                    req[b] = 1'b0;
                    late[b] = 1'b0;
                end else if (req[b] && ack[b]) begin
                    if ($urandom_range(3) == 0) late[b] = 1'b1;
                    else req[b] = 1'b0;
                end else if (!req[b] && $urandom_range(1) == 1) begin
                    req[b] = 1'b1;
                    vote[3*b +: 3] = 3'($urandom_range(7));
                end
            end
        end
        for (int i = 0; i < 6; i++) begin
            tests++;
            if (get_tally(i) !== W'(cnt[i])) begin
                fails++; $display("FAIL rand_tally[%0d]: got %0d expected %0d", i, get_tally(i), cnt[i]);
            end
        end
        mxv = 0;
        for (int i = 0; i < 5; i++) if (cnt[i] > mxv) mxv = cnt[i];
        nw = 0;
        for (int i = 0; i < 5; i++) begin
            ew[i] = (cnt[i] == mxv);
            if (ew[i]) nw++;
        end
        close_and_scan();
        tests++;
        if (mx !== W'(mxv) || win !== ew || tie !== (nw > 1) || rv !== 1'b1) begin
            fails++; $display("FAIL rand_result: max=%0d win=%b tie=%b rv=%b expected %0d %b %0d 1", mx, win, tie, rv, mxv, ew, (nw > 1));
        end
    endtask

    task automatic test_async_reset();
        bit ok;
        do_reset();
        open_poll();
        cast_vote(0, 1, ok);
        cast_vote(1, 3, ok);
        close = 1'b1;
        tick();
        close = 1'b0;
        tick();
        tick();
        tests++;
        if (st !== 2'd2 || tb !== 1 || td !== 1) begin
            fails++; $display("FAIL pre_reset: state=%0d b=%0d d=%0d expected 2 1 1", st, tb, td);
        end
        rst = 1'b0;
        #2;
        tests++;
        if (st !== 2'd0 || {ta, tb, tc, td, te, inv, mx} !== '0 || {win, tie, rv, ack} !== '0 || s_te !== '0) begin
            fails++; $display("FAIL async_reset: state=%0d b=%0d d=%0d rv=%b expected 0 0 0 0", st, tb, td, rv);
        end
        #2;
        rst = 1'b1;
        tick();
        open_poll();
        tests++;
        if (st !== 2'd1 || {ta, tb, tc, td, te, inv} !== '0) begin
            fails++; $display("FAIL post_reset_start: state=%0d b=%0d expected 1 0", st, tb);
        end
    endtask

    initial begin
        test_reset();
        test_single_vote();
        test_tie();
        test_invalid_close();
        test_round_robin();
        test_saturation();
        test_random();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
